// File: rtl/prime_pkg.sv
// Shared types and constants for the 3-bit prime sequence (0->2->3->5->7->0).
// Pure declarations: no latency and no flow control.
package prime_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  localparam logic [2:0] PRIME_FIRST = 3'd0;
  localparam logic [2:0] PRIME_LAST  = 3'd7;

  // Bit v is set when value v is a member of the sequence {0,2,3,5,7}.
  localparam logic [7:0] PRIME_LEGAL_SET = 8'b1010_1101;

  function automatic logic is_prime_legal(input logic [2:0] v);
    return PRIME_LEGAL_SET[v];
  endfunction

endpackage

// File: rtl/prime_seq_monitor_if.sv
// Counter sample stream plus monitor status bundle; PRIME_MON_STICKY_EN adds err_sticky.
// No storage: the monitor drives status, the counter side drives the sample strobe.
interface prime_seq_monitor_if #(
  parameter int ERR_W = 8,
  parameter int PER_W = 16
) ();

  logic             count_valid;
  logic [2:0]       count_in;
  logic             locked;
  logic             err_pulse;
  logic             illegal_value;
  logic [ERR_W-1:0] err_count;
  logic             period_done;
  logic [PER_W-1:0] period_count;
`ifdef PRIME_MON_STICKY_EN
  logic             err_sticky;
`endif

  modport master (
    output count_valid,
    output count_in,
    input  locked,
    input  err_pulse,
    input  illegal_value,
    input  err_count,
    input  period_done,
    input  period_count
`ifdef PRIME_MON_STICKY_EN
    , input err_sticky
`endif
  );

  modport slave (
    input  count_valid,
    input  count_in,
    output locked,
    output err_pulse,
    output illegal_value,
    output err_count,
    output period_done,
    output period_count
`ifdef PRIME_MON_STICKY_EN
    , output err_sticky
`endif
  );

endinterface

// File: rtl/prime_next.sv
// Successor lookup for the prime sequence; illegal inputs return succ=0, is_legal=0.
// Purely combinational, zero latency, no flow control.
module prime_next
  import prime_pkg::*;
(
  input  logic [2:0] val_i,
  output logic [2:0] succ,
  output logic       is_legal
);

  always_comb begin
    succ     = 3'd0;
    is_legal = is_prime_legal(val_i);
    unique case (val_i)
      3'd0:    succ = 3'd2;
      3'd2:    succ = 3'd3;
      3'd3:    succ = 3'd5;
      3'd5:    succ = 3'd7;
      3'd7:    succ = PRIME_FIRST;
      default: succ = 3'd0;
    endcase
  end

endmodule

// File: rtl/prime_seq_monitor.sv
// Locks onto the prime counter stream, then flags/counts sequence errors and periods.
// All outputs registered, one cycle after the valid sample; PRIME_MON_STICKY_EN adds err_sticky.
module prime_seq_monitor
  import prime_pkg::*;
#(
  parameter int LOCK_N = 3,
  parameter int MISS_N = 3,
  parameter int ERR_W  = 8,
  parameter int PER_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  prime_seq_monitor_if.slave   mon
);

  localparam logic [4:0] LOCK_TGT = 5'(LOCK_N);
  localparam logic [4:0] MISS_TGT = 5'(MISS_N);

  state_e           state_q;
  logic [2:0]       prev_q;
  logic [3:0]       run_q;
  logic [3:0]       miss_q;
  logic             locked_q;
  logic             err_pulse_q;
  logic             illegal_q;
  logic             period_done_q;
  logic [ERR_W-1:0] err_count_q;
  logic [PER_W-1:0] period_count_q;

  logic [2:0] prev_succ;
  logic       prev_legal;
  logic       cur_legal;
  logic       match;
  logic       wrap;
  logic       lock_ok;
  logic [4:0] run_inc;
  logic [4:0] miss_inc;

  prime_next u_prev_next (
    .val_i    (prev_q),
    .succ     (prev_succ),
    .is_legal (prev_legal)
  );

  assign cur_legal = is_prime_legal(mon.count_in);
  // An illegal prev has no successor, so it can never match.
  assign match     = prev_legal && (mon.count_in == prev_succ);
  assign wrap      = (prev_q == PRIME_LAST) && (mon.count_in == PRIME_FIRST);
  assign run_inc   = {1'b0, run_q} + 5'd1;
  assign miss_inc  = {1'b0, miss_q} + 5'd1;

`ifdef PRIME_MON_STICKY_EN
  logic err_sticky_q;
  assign lock_ok        = !err_sticky_q;
  assign mon.err_sticky = err_sticky_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_sticky_q <= 1'b0;
    end else if (mon.count_valid && state_q == LOCKED && !match) begin
      err_sticky_q <= 1'b1;
    end
  end
`else
  assign lock_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      prev_q         <= 3'd0;
      run_q          <= 4'd0;
      miss_q         <= 4'd0;
      locked_q       <= 1'b0;
      err_pulse_q    <= 1'b0;
      illegal_q      <= 1'b0;
      period_done_q  <= 1'b0;
      err_count_q    <= '0;
      period_count_q <= '0;
    end else begin
      err_pulse_q   <= 1'b0;
      illegal_q     <= 1'b0;
      period_done_q <= 1'b0;
      if (mon.count_valid) begin
        prev_q <= mon.count_in;
        unique case (state_q)
          IDLE: begin
            state_q <= ACQUIRE;
            run_q   <= 4'd0;
          end
          ACQUIRE: begin
            illegal_q <= !cur_legal;
            if (!match) begin
              run_q <= 4'd0;
            end else if (run_inc == LOCK_TGT && lock_ok) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
              run_q    <= 4'd0;
              miss_q   <= 4'd0;
            end else if (run_inc < LOCK_TGT) begin
              // Blocked lock attempts park the run just below the target.
              run_q <= run_inc[3:0];
            end
          end
          LOCKED: begin
            illegal_q <= !cur_legal;
            if (match) begin
              miss_q <= 4'd0;
              if (wrap) begin
                period_done_q  <= 1'b1;
                period_count_q <= period_count_q + 1'b1;
              end
            end else begin
              err_pulse_q <= 1'b1;
              if (err_count_q != '1) begin
                err_count_q <= err_count_q + 1'b1;
              end
              if (miss_inc == MISS_TGT) begin
                state_q  <= ACQUIRE;
                locked_q <= 1'b0;
                run_q    <= 4'd0;
                miss_q   <= 4'd0;
              end else begin
                miss_q <= miss_inc[3:0];
              end
            end
          end
          default: begin
            state_q  <= IDLE;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign mon.locked        = locked_q;
  assign mon.err_pulse     = err_pulse_q;
  assign mon.illegal_value = illegal_q;
  assign mon.err_count     = err_count_q;
  assign mon.period_done   = period_done_q;
  assign mon.period_count  = period_count_q;

endmodule

// File: tb/tb_prime_seq_monitor.sv
// Drives two monitor configurations from one stimulus stream and checks both against a reference model.
module tb_prime_seq_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       vld;
  logic [2:0] cin;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  prime_seq_monitor_if #(.ERR_W(8), .PER_W(16)) if_a ();
  prime_seq_monitor_if #(.ERR_W(2), .PER_W(16)) if_b ();

  assign if_a.count_valid = vld;
  assign if_a.count_in    = cin;
  assign if_b.count_valid = vld;
  assign if_b.count_in    = cin;

  prime_seq_monitor #(.LOCK_N(3), .MISS_N(3), .ERR_W(8), .PER_W(16)) dut_a (
    .clk(clk), .reset(rst), .mon(if_a.slave)
  );
  prime_seq_monitor #(.LOCK_N(3), .MISS_N(15), .ERR_W(2), .PER_W(16)) dut_b (
    .clk(clk), .reset(rst), .mon(if_b.slave)
  );

  typedef struct {
    int st;      // 0 idle, 1 acquire, 2 locked
    int prev;
    int run;
    int miss;
    int err;
    int per;
    int locked;
    int ep;
    int il;
    int pd;
    int sticky;
  } mdl_t;

  mdl_t ma, mb;

  // -1 marks values outside the sequence.
  function automatic int succ_of(input int v);
    int tbl [8] = '{2, -1, 3, 5, -1, 7, -1, 0};
    return tbl[v];
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input bit r, input bit v, input int c,
                                 input int lock_n, input int miss_n, input int err_max);
    mdl_t n = m;
    bit   ok;
    bit   blocked;
    n.ep = 0; n.il = 0; n.pd = 0;
    if (r) begin
      n = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      return n;
    end
    if (!v) return n;
    ok = (succ_of(m.prev) >= 0) && (c == succ_of(m.prev));
`ifdef PRIME_MON_STICKY_EN
    blocked = (m.sticky != 0);
`else
    blocked = 1'b0;
`endif
    if (m.st == 0) begin
      n.st = 1; n.run = 0;
    end else if (m.st == 1) begin
      n.il = (succ_of(c) < 0);
      if (!ok) n.run = 0;
      else if (m.run + 1 == lock_n && !blocked) begin
        n.st = 2; n.run = 0; n.miss = 0;
      end else if (m.run + 1 < lock_n) n.run = m.run + 1;
    end else begin
      n.il = (succ_of(c) < 0);
      if (ok) begin
        n.miss = 0;
        if (m.prev == 7 && c == 0) begin
          n.pd = 1; n.per = (m.per + 1) % 65536;
        end
      end else begin
        n.ep = 1; n.sticky = 1;
        n.err = (m.err < err_max) ? m.err + 1 : err_max;
        if (m.miss + 1 == miss_n) begin
          n.st = 1; n.run = 0; n.miss = 0;
        end else n.miss = m.miss + 1;
      end
    end
    n.prev   = c;
    n.locked = (n.st == 2);
    return n;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("a.locked", int'(if_a.locked), ma.locked);
    chk("a.err_pulse", int'(if_a.err_pulse), ma.ep);
    chk("a.illegal", int'(if_a.illegal_value), ma.il);
    chk("a.err_count", int'(if_a.err_count), ma.err);
    chk("a.period_done", int'(if_a.period_done), ma.pd);
    chk("a.period_count", int'(if_a.period_count), ma.per);
    chk("b.locked", int'(if_b.locked), mb.locked);
    chk("b.err_pulse", int'(if_b.err_pulse), mb.ep);
    chk("b.illegal", int'(if_b.illegal_value), mb.il);
    chk("b.err_count", int'(if_b.err_count), mb.err);
    chk("b.period_done", int'(if_b.period_done), mb.pd);
    chk("b.period_count", int'(if_b.period_count), mb.per);
`ifdef PRIME_MON_STICKY_EN
    chk("a.err_sticky", int'(if_a.err_sticky), ma.sticky);
    chk("b.err_sticky", int'(if_b.err_sticky), mb.sticky);
`endif
  endtask

  // Inputs change on the falling edge; outputs are checked on the next falling edge.
  task automatic step(input bit r, input bit v, input int c);
    rst = r; vld = v; cin = 3'(c);
    @(posedge clk);
    ma = mstep(ma, r, v, c, 3, 3, 255);
    mb = mstep(mb, r, v, c, 3, 15, 3);
    @(negedge clk);
    compare_all();
  endtask

  task automatic send_seq(input int s []);
    foreach (s[i]) step(0, 1, s[i]);
  endtask

  initial begin
    int last;
    int b_err [6];
    rst = 1'b1; vld = 1'b0; cin = 3'd0;
    ma = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    mb = ma;
    @(negedge clk);
    step(1, 0, 0);
    step(1, 1, 5);
    chk("pin_reset_locked", int'(if_a.locked), 0);
    chk("pin_reset_err", int'(if_a.err_count), 0);

    // Lock and one period.
    send_seq('{0, 2, 3});
    chk("pin_not_yet_locked", int'(if_a.locked), 0);
    step(0, 1, 5);
    chk("pin_locked_after_5", int'(if_a.locked), 1);
    send_seq('{7, 0});
    chk("pin_period_done", int'(if_a.period_done), 1);
    chk("pin_period_count1", int'(if_a.period_count), 1);
    chk("pin_err0", int'(if_a.err_count), 0);

    // Illegal 4 while locked: two mismatches, lock held, 7->0 recovers.
    send_seq('{2, 3});
    step(0, 1, 4);
    chk("pin_illegal_4", int'(if_a.illegal_value), 1);
    chk("pin_err_pulse_4", int'(if_a.err_pulse), 1);
    step(0, 1, 7);
    chk("pin_illegal_7", int'(if_a.illegal_value), 0);
    chk("pin_err_pulse_7", int'(if_a.err_pulse), 1);
    step(0, 1, 0);
    chk("pin_err2", int'(if_a.err_count), 2);
    chk("pin_still_locked", int'(if_a.locked), 1);
    chk("pin_period_count2", int'(if_a.period_count), 2);

    // Three mismatches drop lock in dut_a, then relock.
    send_seq('{0, 0});
    chk("pin_locked_before_3rd", int'(if_a.locked), 1);
    step(0, 1, 0);
    chk("pin_unlocked", int'(if_a.locked), 0);
    chk("pin_err5", int'(if_a.err_count), 5);
    send_seq('{2, 3, 5});
    chk("pin_relocked", int'(if_a.locked), 1);
    step(0, 1, 7);

    // Saturation in dut_b (ERR_W=2, MISS_N=15).
    step(1, 0, 0);
    send_seq('{0, 2, 3, 5, 7, 0});
    b_err = '{1, 2, 3, 3, 3, 3};
    foreach (b_err[i]) begin
      step(0, 1, 0);
      chk("pin_b_err_sat", int'(if_b.err_count), b_err[i]);
    end
    chk("pin_b_locked", int'(if_b.locked), 1);

    // Gapped valid stream locks the same way; idle cycles carry no pulses.
    step(1, 0, 0);
    foreach (b_err[i]) begin
      int sq [6] = '{0, 2, 3, 5, 7, 0};
      step(0, 1, sq[i]);
      if (i == 3) chk("pin_gap_locked", int'(if_a.locked), 1);
      if (i == 5) chk("pin_gap_period", int'(if_a.period_done), 1);
      step(0, 0, 4);
      chk("pin_gap_no_pd", int'(if_a.period_done), 0);
      step(0, 0, 6);
    end
    chk("pin_gap_per_count", int'(if_a.period_count), 1);

    // Reset beats a simultaneous valid sample.
    step(1, 1, 2);
    chk("pin_rst_locked", int'(if_a.locked), 0);
    chk("pin_rst_per", int'(if_a.period_count), 0);
    step(0, 1, 4);
    chk("pin_first_no_illegal", int'(if_a.illegal_value), 0);
    chk("pin_first_no_err", int'(if_a.err_pulse), 0);

    // Randomized stream, mostly well-formed with injected faults and resets.
    last = 4;
    for (int i = 0; i < 4000; i++) begin
      bit r;
      bit v;
      int c;
      r = ($urandom_range(0, 299) == 0);
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) < 8 && succ_of(last) >= 0) c = succ_of(last);
      else c = $urandom_range(0, 7);
      step(r, v, c);
      if (v && !r) last = c;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prime_seq_monitor.md
# prime_seq_monitor

Downstream checker for the 3-bit prime counter output stream (legal cycle 0→2→3→5→7→0). The block samples the count on a valid strobe and locks onto the sequence after a run of correct transitions. Once locked, it flags and counts sequence errors and counts completed periods. It sits between the counter and the board status LEDs/display logic as a self-check and period tick source.

## Interface
- LOCK_N, 3, consecutive correct transitions needed to enter LOCKED (1..15)
- MISS_N, 3, consecutive mismatches in LOCKED that drop lock (1..15)
- ERR_W, 8, width of saturating error counter
- PER_W, 16, width of wrapping period counter
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- count_valid  in  1  sample strobe; count_in is ignored when low
- count_in  in  3  counter value under check
- locked  out  1  high while in LOCKED
- err_pulse  out  1  one-cycle pulse per mismatch in LOCKED
- illegal_value  out  1  one-cycle pulse when a sampled value is not in {0,2,3,5,7}, in any state except IDLE's first sample
- err_count  out  ERR_W  mismatches in LOCKED, saturating at all-ones
- period_done  out  1  one-cycle pulse on a 7→0 transition while LOCKED
- period_count  out  PER_W  number of period_done pulses, wraps modulo 2^PER_W

## Operation
- Successor: succ(0)=2, succ(2)=3, succ(3)=5, succ(5)=7, succ(7)=0. The values 1, 4 and 6 are illegal and have no successor.
- match = prev is legal AND count_in == succ(prev). An illegal prev always yields a mismatch.
- prev is updated with count_in on every valid sample, in every state.
- FSM states:
  - IDLE: on a valid sample, capture prev and go to ACQUIRE with run=0. No checking on this sample.
  - ACQUIRE:
    - valid & match: run+1. When run+1==LOCK_N, go to LOCKED with miss=0.
    - valid & mismatch: run=0. No err_pulse and no err_count change.
  - LOCKED:
    - valid & match: miss=0. If prev==7 and count_in==0, pulse period_done and increment period_count.
    - valid & mismatch: pulse err_pulse, increment err_count (saturating), miss+1. When miss+1==MISS_N, go to ACQUIRE with run=0. Lock drops on that same sample.
- illegal_value is evaluated in ACQUIRE and LOCKED. It is independent of match.
- A cycle with valid low changes nothing, and every pulse output is low in that cycle.
- Illegal sample while LOCKED: it counts as one mismatch, and the following sample is a second mismatch because prev is now illegal.

## Timing
- All outputs are registered. Every response appears on the cycle after the valid sample that caused it.
- Pulses last exactly one cycle. Back-to-back valid samples can give back-to-back pulses.
- locked rises on the cycle after the LOCK_N-th matching sample. It falls on the cycle after the MISS_N-th consecutive mismatch.
- Reset values: state IDLE, prev=0, run=0, miss=0, and every output 0 (locked, err_pulse, illegal_value, err_count, period_done, period_count).
- reset wins over count_valid in the same cycle. Reset mid-operation discards prev and all counters.
- err_count holds at 2^ERR_W−1 once saturated. period_count wraps from 2^PER_W−1 to 0.

## Configuration
- PRIME_MON_STICKY_EN defined:
  - Adds output err_sticky (1 bit, reset 0). It sets on the cycle err_pulse asserts and clears only on reset.
  - LOCKED is entered only while err_sticky is 0. After any error, the block stays out of LOCKED until reset.
- Not defined: no err_sticky port, and relocking after an error is unrestricted.

## Structure
- Shared package prime_pkg holds:
  - state enum {IDLE, ACQUIRE, LOCKED}
  - constants PRIME_FIRST=3'd0 and PRIME_LAST=3'd7
  - legal-value set
- Sub-module prime_next (combinational): input a 3-bit value, outputs succ[2:0] and is_legal. It is reused by any future generator or checker.
- The top holds the FSM, prev register, run/miss counters and output registers.

## Test plan
- Reset, then valid every cycle with 0,2,3,5,7,0 (LOCK_N=3) → locked=1 on the cycle after the sample 5. period_done pulses on the cycle after the final 0. period_count=1, err_count=0.
- While locked, send 2,3,4,7,0 → illegal_value pulses once, for the 4. err_pulse pulses twice (for 4 and 7). err_count=2. locked stays 1 with MISS_N=3. The final 7→0 match resets miss.
- While locked, send 3 mismatches (0,0,0 after a 0) → 3 err_pulses, and locked=0 on the cycle after the third. The sequence 2,3,5,7 then relocks.
- ERR_W=2, force 6 mismatches in LOCKED with MISS_N=15 → err_count reads 1,2,3,3,3,3.
- Valid low for 2 cycles between each legal sample → locking happens with identical counts. No pulses occur in idle cycles.
- Reset asserted together with count_valid while locked → next cycle all outputs are 0 and state is IDLE. The next valid sample produces no pulse.
